dff_chain_sequencer: RTL and testbench

DFF_CHAIN_SEQUENCER -- requirements
Module: dff_chain_sequencer

---
 rtl/dff_chain_pkg.sv | 22 ++
 rtl/dff_chain_bit_counter.sv | 29 ++
 rtl/dff_chain_sequencer.sv | 99 +++++++++
 tb/tb_dff_chain_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dff_chain_pkg.sv
// rtl/dff_chain_pkg.sv - shared FSM encoding and command codes for the DFF chain sequencer
package dff_chain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_PRESET = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] CMD_LOAD   = 2'b00;
  localparam logic [1:0] CMD_PRESET = 2'b01;
  localparam logic [1:0] CMD_CLEAR  = 2'b10;
  localparam logic [1:0] CMD_RSVD   = 2'b11;

  // Counter must hold WIDTH itself when the parity slot is enabled.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/dff_chain_bit_counter.sv
// rtl/dff_chain_bit_counter.sv - loadable up-counter with terminal-count flag, wraps to 0 after LAST
module dff_chain_bit_counter #(
  parameter int CNT_W = 4,
  parameter int LAST  = 7
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Load,
  input  logic [CNT_W-1:0] Load_Value,
  input  logic             Enable,
  output logic [CNT_W-1:0] Count,
  output logic             Terminal
);

  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(LAST);

  assign Terminal = (Count == LAST_V);

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      Count <= '0;
    end else if (Load) begin
      Count <= Load_Value;
    end else if (Enable) begin
      Count <= Terminal ? '0 : Count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dff_chain_sequencer.sv
// rtl/dff_chain_sequencer.sv - command FSM driving serial load, preset and clear of a DFF chain
// Optional even-parity trailer bit enabled by defining DFF_CHAIN_PARITY_EN.
module dff_chain_sequencer
  import dff_chain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [1:0]       Cmd,
  input  logic [WIDTH-1:0] In_Data,
  output logic             Ser_D,
  output logic             Shift_En,
  output logic             Bank_Preset,
  output logic             Bank_Clear,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  localparam int CNT_W = cnt_width(WIDTH);
`ifdef DFF_CHAIN_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  state_t           state_q;
  logic [1:0]       cmd_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             bit_tc;
  logic             accept;
  logic [WIDTH-1:0] bit_mask;
  logic             ser_bit;

  assign accept = In_Valid && In_Ready;

  dff_chain_bit_counter #(
    .CNT_W (CNT_W),
    .LAST  (LAST)
  ) u_bit_counter (
    .Clock      (Clock),
    .Clear      (Clear),
    .Load       (accept),
    .Load_Value ('0),
    .Enable     (state_q == ST_SHIFT),
    .Count      (bit_cnt),
    .Terminal   (bit_tc)
  );

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_LOAD;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_q  <= Cmd;
            data_q <= In_Data;
            case (Cmd)
              CMD_LOAD:   state_q <= ST_SHIFT;
              CMD_PRESET: state_q <= ST_PRESET;
              CMD_CLEAR:  state_q <= ST_CLEAR;
              default:    state_q <= ST_DONE;
            endcase
          end
        end
        ST_SHIFT:  if (bit_tc) state_q <= ST_DONE;
        ST_PRESET: state_q <= ST_DONE;
        ST_CLEAR:  state_q <= ST_DONE;
        ST_DONE:   state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Mask select keeps every captured bit in use; mask is zero in the parity slot.
  assign bit_mask = WIDTH'(1) << bit_cnt;
`ifdef DFF_CHAIN_PARITY_EN
  assign ser_bit = (bit_cnt == CNT_W'(WIDTH)) ? ^data_q : |(data_q & bit_mask);
`else
  assign ser_bit = |(data_q & bit_mask);
`endif

  assign In_Ready    = (state_q == ST_IDLE) && !Clear;
  assign Busy        = (state_q != ST_IDLE);
  assign Shift_En    = (state_q == ST_SHIFT);
  assign Ser_D       = (state_q == ST_SHIFT) && ser_bit;
  assign Bank_Preset = (state_q == ST_PRESET);
  assign Bank_Clear  = (state_q == ST_CLEAR);
  assign Done        = (state_q == ST_DONE);
  assign Err         = (state_q == ST_DONE) && (cmd_q == CMD_RSVD);

endmodule

// File: tb/tb_dff_chain_sequencer.sv
// tb/tb_dff_chain_sequencer.sv - table, directed and random checks of dff_chain_sequencer at WIDTH=8
module tb_dff_chain_sequencer;

  localparam int W = 8;
`ifdef DFF_CHAIN_PARITY_EN
  localparam int SLEN = W + 1;
`else
  localparam int SLEN = W;
`endif

  logic         Clock = 1'b0;
  logic         Clear, In_Valid, In_Ready;
  logic [1:0]   Cmd;
  logic [W-1:0] In_Data;
  logic         Ser_D, Shift_En, Bank_Preset, Bank_Clear, Busy, Done, Err;

  always #5 Clock = ~Clock;

  dff_chain_sequencer #(.WIDTH(W)) dut (
    .Clock       (Clock),
    .Clear       (Clear),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .Cmd         (Cmd),
    .In_Data     (In_Data),
    .Ser_D       (Ser_D),
    .Shift_En    (Shift_En),
    .Bank_Preset (Bank_Preset),
    .Bank_Clear  (Bank_Clear),
    .Busy        (Busy),
    .Done        (Done),
    .Err         (Err)
  );

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] data;
    int         done_at;
  } vec_t;

  int         n_vec = 0;
  int         n_mis = 0;
  logic [7:0] exp_q[$];
  vec_t       tbl[7];

  // Observed vector: {In_Ready,Busy,Done,Err,Shift_En,Ser_D,Bank_Preset,Bank_Clear}
  function automatic logic [7:0] obs();
    return {In_Ready, Busy, Done, Err, Shift_En, Ser_D, Bank_Preset, Bank_Clear};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference trace per command, cycle k+1 onward, ending with the first idle cycle.
  function automatic void build(input logic [1:0] c, input logic [7:0] d);
    logic b;
    exp_q.delete();
    if (c == 2'b00) begin
      for (int i = 0; i < SLEN; i++) begin
        if (i < W) b = d[i];
        else       b = ^d;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b1, b, 1'b0, 1'b0});
      end
    end else if (c == 2'b01) begin
      exp_q.push_back(8'b0100_0010);
    end else if (c == 2'b10) begin
      exp_q.push_back(8'b0100_0001);
    end
    exp_q.push_back({1'b0, 1'b1, 1'b1, (c == 2'b11), 4'b0000});
    exp_q.push_back(8'b1000_0000);
  endfunction

  task automatic issue(input string tag, input logic [1:0] c, input logic [7:0] d,
                       input bit chain, input logic [1:0] nc, input logic [7:0] nd,
                       input bit noise, output int done_at);
    In_Valid = 1'b1;
    Cmd      = c;
    In_Data  = d;
    build(c, d);
    done_at = -1;
    @(posedge Clock);
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge Clock);
      if (j == 0) begin
        if (chain) begin
          Cmd     = nc;
          In_Data = nd;
        end else begin
          In_Valid = 1'b0;
        end
      end
      if (noise) begin
        In_Valid = (j % 2 == 0) && (j < exp_q.size() - 1);
        In_Data  = 8'h3C;
      end
      #1;
      check($sformatf("%s cyc%0d", tag, j + 1), {24'd0, obs()}, {24'd0, exp_q[j]});
      if (done_at < 0 && Done) done_at = j + 1;
    end
  endtask

  initial begin
    int         da;
    logic [1:0] cur_c, nxt_c;
    logic [7:0] cur_d, nxt_d;
    bit         chain;

    tbl[0] = '{2'b00, 8'hA5, SLEN + 1};
    tbl[1] = '{2'b00, 8'h00, SLEN + 1};
    tbl[2] = '{2'b00, 8'hFF, SLEN + 1};
    tbl[3] = '{2'b01, 8'h5A, 2};
    tbl[4] = '{2'b10, 8'h81, 2};
    tbl[5] = '{2'b11, 8'h42, 1};
    tbl[6] = '{2'b00, 8'h07, SLEN + 1};

    Clear    = 1'b1;
    In_Valid = 1'b0;
    Cmd      = 2'b00;
    In_Data  = 8'h00;
    repeat (2) @(negedge Clock);
    check("reset_outputs", {24'd0, obs()}, 32'h0);
    Clear = 1'b0;
    #1;
    check("post_reset_idle", {24'd0, obs()}, 32'h80);

    for (int i = 0; i < 7; i++) begin
      issue($sformatf("tbl%0d", i), tbl[i].cmd, tbl[i].data, 1'b0, 2'b00, 8'h00, 1'b0, da);
      check($sformatf("tbl%0d done_lat", i), da, tbl[i].done_at);
    end

    // PRESET then CLEAR with In_Valid held through DONE
    issue("b2b_preset", 2'b01, 8'h00, 1'b1, 2'b10, 8'h00, 1'b0, da);
    issue("b2b_clear", 2'b10, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, da);

    // New data offered while busy must not disturb the captured word
    issue("busy_ignore", 2'b00, 8'hC3, 1'b0, 2'b00, 8'h00, 1'b1, da);

    // Clear pulsed mid-shift aborts at once, then a normal LOAD follows
    In_Valid = 1'b1;
    Cmd      = 2'b00;
    In_Data  = 8'hFF;
    @(posedge Clock);
    for (int j = 0; j < 4; j++) begin
      @(negedge Clock);
      In_Valid = 1'b0;
      #1;
      check($sformatf("abort shift%0d", j), {24'd0, obs()}, 32'h4C);
    end
    @(negedge Clock);
    Clear = 1'b1;
    #1;
    check("abort immediate", {24'd0, obs()}, 32'h0);
    @(negedge Clock);
    check("abort held", {24'd0, obs()}, 32'h0);
    Clear = 1'b0;
    #1;
    check("abort released", {24'd0, obs()}, 32'h80);
    issue("after_abort", 2'b00, 8'h01, 1'b0, 2'b00, 8'h00, 1'b0, da);
    check("after_abort done_lat", da, SLEN + 1);

    // Random commands, randomly chained back-to-back
    cur_c = 2'($urandom_range(0, 3));
    cur_d = 8'($urandom);
    for (int n = 0; n < 40; n++) begin
      nxt_c = 2'($urandom_range(0, 3));
      nxt_d = 8'($urandom);
      chain = (n < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      issue($sformatf("rnd%0d", n), cur_c, cur_d, chain, nxt_c, nxt_d, 1'b0, da);
      if (!chain) begin
        @(negedge Clock);
        #1;
      end
      cur_c = nxt_c;
      cur_d = nxt_d;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
